fetch_align: RTL and testbench

// - Instruction fetch front end that sits directly upstream of the RVC expander.
// - Issues word-aligned fetches to instruction memory and buffers the returned 16-bit parcels.
// - Presents one complete instruction per handshake on instr_raw[INSTRUCTION_WIDTH-1:0]:
//   - a 16-bit parcel is zero-extended;
//   - a 32-bit instruction is reassembled, including one that straddles a word boundary.
// - Handles redirects (branch/jump/trap) to any halfword-aligned PC.

---
 rtl/fetch_align_if.sv | 25 ++
 rtl/fetch_align.sv | 124 ++++++++++++
 tb/tb_fetch_align.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_align_if.sv
// Fetch front-end bundle: instruction-memory port, redirect input and the
// instruction handshake toward the RVC expander.
interface fetch_align_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_raw;
  logic [31:0] instr_pc;

  modport master (
    output imem_req, imem_addr, instr_valid, instr_raw, instr_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr_raw, instr_pc,
    output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, instr_ready
  );
endinterface

// File: rtl/fetch_align.sv
// Instruction fetch aligner: word fetches into a halfword FIFO, one whole instruction
// per handshake. Define FETCH_ALIGN_COMPRESSED_EN to accept 16-bit (RVC) parcels.
module fetch_align #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned BUF_HW   = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_align_if.master bus
);

  localparam int unsigned CW = $clog2(BUF_HW + 1);
  localparam int unsigned BW = 16 * BUF_HW;

`ifdef FETCH_ALIGN_COMPRESSED_EN
  localparam logic [31:0] PC_MASK = 32'hFFFF_FFFE;
`else
  localparam logic [31:0] PC_MASK = 32'hFFFF_FFFC;
`endif

  // Parcel FIFO packed into one vector; parcel 0 (the head) sits in [15:0].
  logic [BW-1:0] hw_q;
  logic [BW-1:0] hw_n;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_n;
  logic [CW-1:0] base;
  logic [31:0]   fetch_addr;
  logic [31:0]   pc_q;
  logic [31:0]   raw_q;
  logic [31:0]   raw_c;
  logic          outstanding;
  logic          drop;
  logic          skip;
  logic          skip_set;
  logic          run;
  logic          is16;
  logic          valid;
  logic          hs;
  logic          grant;
  logic          push_two;
  logic          push_one;
  logic [1:0]    pop;

`ifdef FETCH_ALIGN_COMPRESSED_EN
  assign is16     = (hw_q[1:0] != 2'b11);
  assign skip_set = bus.redirect_pc[1];
`else
  assign is16     = 1'b0;
  assign skip_set = 1'b0;
`endif

  assign valid = ((count_q >= CW'(1)) && is16) || (count_q >= CW'(2));
  assign raw_c = is16 ? {16'h0000, hw_q[15:0]} : hw_q[31:0];

  assign bus.instr_valid = valid;
  assign bus.instr_raw   = valid ? raw_c : raw_q;
  assign bus.instr_pc    = pc_q;
  assign bus.imem_addr   = fetch_addr;
  // run keeps imem_req low during reset and for the first cycle after release.
  assign bus.imem_req    = run && !outstanding && !bus.redirect_valid &&
                           ((32'(count_q) + 32'd2) <= BUF_HW);

  assign grant    = bus.imem_req && bus.imem_gnt;
  assign hs       = valid && bus.instr_ready && !bus.redirect_valid;
  assign push_two = bus.imem_rvalid && !drop && !skip && !bus.redirect_valid;
  assign push_one = bus.imem_rvalid && !drop &&  skip && !bus.redirect_valid;

  // Pop first, then append the response behind whatever survives the pop.
  always_comb begin
    pop = 2'd0;
    if (hs) pop = is16 ? 2'd1 : 2'd2;
    hw_n = hw_q;
    if (pop == 2'd1)      hw_n = hw_q >> 16;
    else if (pop == 2'd2) hw_n = hw_q >> 32;
    base    = count_q - CW'(pop);
    count_n = base;
    for (int unsigned i = 0; i < BUF_HW; i++) begin
      if (push_two && (CW'(i) == base))          hw_n[16*i +: 16] = bus.imem_rdata[15:0];
      if (push_two && (CW'(i) == base + CW'(1))) hw_n[16*i +: 16] = bus.imem_rdata[31:16];
      if (push_one && (CW'(i) == base))          hw_n[16*i +: 16] = bus.imem_rdata[31:16];
    end
    if (push_two)      count_n = base + CW'(2);
    else if (push_one) count_n = base + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hw_q        <= '0;
      count_q     <= '0;
      fetch_addr  <= RESET_PC;
      pc_q        <= RESET_PC;
      raw_q       <= '0;
      outstanding <= 1'b0;
      drop        <= 1'b0;
      skip        <= 1'b0;
      run         <= 1'b0;
    end else begin
      run <= 1'b1;
      if (valid) raw_q <= raw_c;

      if (grant)                 outstanding <= 1'b1;
      else if (bus.imem_rvalid)  outstanding <= 1'b0;

      if (bus.redirect_valid) begin
        count_q    <= '0;
        pc_q       <= bus.redirect_pc & PC_MASK;
        fetch_addr <= bus.redirect_pc & 32'hFFFF_FFFC;
        skip       <= skip_set;
        // A fetch still in flight will return data for the old path.
        drop       <= outstanding && !bus.imem_rvalid;
      end else begin
        hw_q    <= hw_n;
        count_q <= count_n;
        if (grant) fetch_addr <= fetch_addr + 32'd4;
        if (hs)    pc_q <= pc_q + (is16 ? 32'd2 : 32'd4);
        if (bus.imem_rvalid) begin
          if (drop)      drop <= 1'b0;
          else if (skip) skip <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_align.sv
// Scoreboard bench for fetch_align: a memory responder answers grants, directed
// sequences push expected (pc, raw) pairs, a monitor checks every handshake.
module tb_fetch_align;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] raw;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  int   lat = 0;
  exp_t sbq[$];

  always #5 clk = ~clk;

  fetch_align_if bus ();

  fetch_align #(.RESET_PC(32'h0000_0000), .BUF_HW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h00A0_0093;
      32'h0000_0004: return 32'h0011_0113;
      32'h0000_0008: return 32'h0020_8193;
      32'h0000_000C: return 32'h0031_0213;
      32'h0000_0100: return 32'h4505_0001;
      32'h0000_0200: return 32'hDEAD_BEEF;
      32'h0000_0300: return 32'h0041_0293;
      32'h0000_0304: return 32'h0051_0313;
      32'h0000_0400: return 32'h0093_4501;
      32'h0000_0404: return 32'h0001_00A0;
      32'hFFFF_FFFC: return 32'h0061_0393;
      default:       return 32'h0000_0013;
    endcase
  endfunction

  // Memory: rvalid arrives (lat+1) cycles after the grant, held for one cycle.
  initial begin
    logic [31:0] a;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.imem_req && bus.imem_gnt) begin
        a = bus.imem_addr;
        repeat (lat) @(posedge clk);
        @(posedge clk); #1;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = mem_word(a);
        @(posedge clk); #1;
        bus.imem_rvalid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.instr_valid && bus.instr_ready && !bus.redirect_valid) begin
      vectors++;
      if (sbq.size() == 0) begin
        miscompares++;
        $display("FAIL extra_instr: got pc %h raw %h, expected no instruction",
                 bus.instr_pc, bus.instr_raw);
      end else begin
        e = sbq.pop_front();
        if (bus.instr_pc !== e.pc || bus.instr_raw !== e.raw) begin
          miscompares++;
          $display("FAIL instr: got pc %h raw %h, expected pc %h raw %h",
                   bus.instr_pc, bus.instr_raw, e.pc, e.raw);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, want);
    end
  endtask

  task automatic expect_instr(input logic [31:0] pc, input logic [31:0] raw);
    exp_t e;
    e.pc  = pc;
    e.raw = raw;
    sbq.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Accept exactly n instructions, then drop instr_ready again.
  task automatic consume(input int n);
    int got = 0;
    int cyc = 0;
    bus.instr_ready = 1'b1;
    while (got < n && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (rst_n && bus.instr_valid && !bus.redirect_valid) got++;
    end
    @(posedge clk); #1;
    bus.instr_ready = 1'b0;
    if (got < n) begin
      vectors++;
      miscompares++;
      $display("FAIL consume_timeout: got %0d instructions, expected %0d", got, n);
    end
  endtask

  task automatic redirect(input logic [31:0] pc);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = pc;
    @(posedge clk); #1;
    bus.redirect_valid = 1'b0;
  endtask

  initial begin
    bus.imem_gnt       = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.instr_ready    = 1'b0;

    #12;
    check("rst_valid", {31'b0, bus.instr_valid}, 32'h0);
    check("rst_req",   {31'b0, bus.imem_req},    32'h0);
    check("rst_addr",  bus.imem_addr,            32'h0000_0000);
    check("rst_raw",   bus.instr_raw,            32'h0000_0000);
    check("rst_pc",    bus.instr_pc,             32'h0000_0000);
    @(posedge clk); #1;
    rst_n = 1'b1;

    expect_instr(32'h0000_0000, 32'h00A0_0093);
    expect_instr(32'h0000_0004, 32'h0011_0113);
    consume(2);

    // Backpressure: buffer fills, fetch stops, nothing is lost afterwards.
    idle(20);
    @(negedge clk);
    check("req_stop_full", {31'b0, bus.imem_req}, 32'h0);
    @(posedge clk); #1;
    expect_instr(32'h0000_0008, 32'h0020_8193);
    expect_instr(32'h0000_000C, 32'h0031_0213);
    consume(2);
    idle(20);

    // Second redirect lands while the 0x200 fetch is still in flight.
    lat = 3;
    redirect(32'h0000_0200);
    @(negedge clk);
    check("redir_req",  {31'b0, bus.imem_req}, 32'h1);
    check("redir_addr", bus.imem_addr,         32'h0000_0200);
    @(posedge clk); #1;
    redirect(32'h0000_0300);
    lat = 0;
    expect_instr(32'h0000_0300, 32'h0041_0293);
    expect_instr(32'h0000_0304, 32'h0051_0313);
    consume(2);
    idle(10);

    redirect(32'h0000_0400);
`ifdef FETCH_ALIGN_COMPRESSED_EN
    expect_instr(32'h0000_0400, 32'h0000_4501);
    expect_instr(32'h0000_0402, 32'h00A0_0093);
    expect_instr(32'h0000_0406, 32'h0000_0001);
    consume(3);
`else
    expect_instr(32'h0000_0400, 32'h0093_4501);
    expect_instr(32'h0000_0404, 32'h0001_00A0);
    consume(2);
`endif
    idle(10);

    redirect(32'h0000_0102);
`ifdef FETCH_ALIGN_COMPRESSED_EN
    expect_instr(32'h0000_0102, 32'h0000_4505);
`else
    expect_instr(32'h0000_0100, 32'h4505_0001);
`endif
    consume(1);
    idle(10);

    redirect(32'hFFFF_FFFC);
    expect_instr(32'hFFFF_FFFC, 32'h0061_0393);
    expect_instr(32'h0000_0000, 32'h00A0_0093);
    consume(2);

    // Asynchronous reset in the middle of a cycle with a full buffer.
    idle(20);
    @(negedge clk);
    check("pre_rst_valid", {31'b0, bus.instr_valid}, 32'h1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'b0, bus.instr_valid}, 32'h0);
    check("mid_rst_req",   {31'b0, bus.imem_req},    32'h0);
    check("mid_rst_pc",    bus.instr_pc,             32'h0000_0000);
    check("mid_rst_raw",   bus.instr_raw,            32'h0000_0000);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_addr", bus.imem_addr, 32'h0000_0000);
    @(posedge clk); #1;
    expect_instr(32'h0000_0000, 32'h00A0_0093);
    expect_instr(32'h0000_0004, 32'h0011_0113);
    consume(2);

    idle(5);
    check("sb_empty", 32'(sbq.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
